// File: rtl/control_sequencer.sv
// Hardwired Moore controller for the register-ALU datapath: fetch in T0-T2, execute in T3-T6.
// Control strobes are a decode of the state register and IR; an instruction counter and a sticky memory-timeout flag are kept alongside.
module control_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             MemReady,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic [3:0]       operation,
  output logic             Run,
  output logic             ill_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    C_BIN, C_MULDIV, C_UNARY, C_NOP, C_ILL, C_HALT
  } class_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_next;
  class_t     cls;
  logic [7:0] wait_cnt, wait_next;
  logic [3:0] alu_op;
  logic       mem_err_set, instr_done;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  function automatic logic [15:0] onehot(input logic [3:0] n);
    return 16'(1) << n;
  endfunction

  always_comb begin
    cls    = C_ILL;
    alu_op = 4'd0;
    case (op)
      5'b00011: begin cls = C_BIN;    alu_op = 4'd1;  end
      5'b00100: begin cls = C_BIN;    alu_op = 4'd2;  end
      5'b00101: begin cls = C_BIN;    alu_op = 4'd3;  end
      5'b00110: begin cls = C_BIN;    alu_op = 4'd4;  end
      5'b00111: begin cls = C_BIN;    alu_op = 4'd5;  end
      5'b01000: begin cls = C_BIN;    alu_op = 4'd6;  end
      5'b01001: begin cls = C_BIN;    alu_op = 4'd7;  end
      5'b01010: begin cls = C_BIN;    alu_op = 4'd8;  end
      5'b01110: begin cls = C_MULDIV; alu_op = 4'd9;  end
      5'b01111: begin cls = C_MULDIV; alu_op = 4'd10; end
      5'b10000: begin cls = C_UNARY;  alu_op = 4'd11; end
      5'b10001: begin cls = C_UNARY;  alu_op = 4'd12; end
      5'b11010: cls = C_NOP;
      5'b11011: cls = C_HALT;
      default:  cls = C_ILL;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state     <= S_RST;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (mem_err_set) mem_err <= 1'b1;
      if (instr_done)  instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next  = state;
    wait_next   = wait_cnt;
    mem_err_set = 1'b0;
    instr_done  = 1'b0;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    Rout = '0; Rin = '0; operation = '0;
    Run = 1'b1; ill_op = 1'b0;
    case (state)
      S_RST: state_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        wait_next  = '0;
        state_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (MemReady) begin
          wait_next  = '0;
          state_next = S_T2;
        end else begin
          wait_next = wait_cnt + 8'd1;
          if (wait_cnt == WAIT_LAST) begin
            mem_err_set = 1'b1;
            state_next  = S_HALTED;
          end
        end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        state_next = S_T4;
        case (cls)
          C_BIN:    begin Rout = onehot(rb); Yin = 1'b1; end
          C_MULDIV: begin Rout = onehot(ra); Yin = 1'b1; end
          C_UNARY:  begin Rout = onehot(rb); operation = alu_op; Zin = 1'b1; end
          C_HALT:   begin instr_done = 1'b1; state_next = S_HALTED; end
          C_ILL:    begin ill_op = 1'b1; instr_done = 1'b1; state_next = S_T0; end
          default:  begin instr_done = 1'b1; state_next = S_T0; end
        endcase
      end
      S_T4: begin
        state_next = S_T0;
        case (cls)
          C_BIN:    begin Rout = onehot(rc); operation = alu_op; Zin = 1'b1; state_next = S_T5; end
          C_MULDIV: begin Rout = onehot(rb); operation = alu_op; Zin = 1'b1; state_next = S_T5; end
          C_UNARY: begin
            // R0 is hardwired read-only, so its load strobe is masked off
            Zlowout = 1'b1; Rin = onehot(ra) & 16'hFFFE; instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        Zlowout    = 1'b1;
        state_next = S_T0;
        if (cls == C_MULDIV) begin
          LOin = 1'b1; state_next = S_T6;
        end else begin
          Rin = onehot(ra) & 16'hFFFE; instr_done = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
        state_next = S_T0;
      end
      S_HALTED: Run = 1'b0;
      default:  state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small bench datapath answers the strobes, and a per-cycle queue of expected outputs is checked.
module tb_control_sequencer;

  logic        Clock, clear, MemReady, preload;
  logic [31:0] IR;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
  logic Yin, Zin, HIin, LOin, IncPC, Read, Run, ill_op, mem_err;
  logic [15:0] Rout, Rin, instr_cnt;
  logic [3:0]  operation;

  logic d2_PCout, d2_Zlowout, d2_Zhighout, d2_MDRout, d2_MARin, d2_PCin, d2_MDRin, d2_IRin;
  logic d2_Yin, d2_Zin, d2_HIin, d2_LOin, d2_IncPC, d2_Read, d2_Run, d2_ill_op, d2_mem_err;
  logic [15:0] d2_Rout, d2_Rin;
  logic [3:0]  d2_operation;
  logic [1:0]  d2_instr_cnt;

  control_sequencer #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .MemReady(MemReady),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Rout(Rout), .Rin(Rin),
    .operation(operation), .Run(Run), .ill_op(ill_op), .mem_err(mem_err),
    .instr_cnt(instr_cnt)
  );

  control_sequencer #(.CNT_W(2), .MEM_TIMEOUT(15)) dut2 (
    .Clock(Clock), .clear(clear), .IR(IR), .MemReady(MemReady),
    .PCout(d2_PCout), .Zlowout(d2_Zlowout), .Zhighout(d2_Zhighout), .MDRout(d2_MDRout),
    .MARin(d2_MARin), .PCin(d2_PCin), .MDRin(d2_MDRin), .IRin(d2_IRin), .Yin(d2_Yin),
    .Zin(d2_Zin), .HIin(d2_HIin), .LOin(d2_LOin), .IncPC(d2_IncPC), .Read(d2_Read),
    .Rout(d2_Rout), .Rin(d2_Rin), .operation(d2_operation), .Run(d2_Run),
    .ill_op(d2_ill_op), .mem_err(d2_mem_err), .instr_cnt(d2_instr_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Minimal datapath reacting to the strobes
  logic [31:0] regs [16];
  logic [31:0] pc, mdr, ir_q, y, hi, lo, bus, mem_word;
  logic [63:0] z;

  assign IR = ir_q;

  always_comb begin
    bus = '0;
    if (PCout)    bus = bus | pc;
    if (Zlowout)  bus = bus | z[31:0];
    if (Zhighout) bus = bus | z[63:32];
    if (MDRout)   bus = bus | mdr;
    for (int n = 0; n < 16; n++) if (Rout[n]) bus = bus | regs[n];
  end

  always @(posedge Clock) begin
    if (preload) begin
      for (int n = 0; n < 16; n++) regs[n] <= 32'h0;
      regs[2] <= 32'h12; regs[3] <= 32'h14; regs[4] <= 32'h10; regs[5] <= 32'h3;
      pc <= 32'h0; ir_q <= 32'h0; hi <= 32'h0; lo <= 32'h0;
    end else begin
      if (PCin) pc <= bus;
      if (MDRin && MemReady) mdr <= mem_word;
      if (IRin) ir_q <= bus;
      if (Yin)  y <= bus;
      if (HIin) hi <= bus;
      if (LOin) lo <= bus;
      if (Zin) begin
        case (operation)
          4'd1:    z <= {32'h0, y + bus};
          4'd9:    z <= {32'h0, y} * {32'h0, bus};
          4'd11:   z <= {32'h0, 32'h0 - bus};
          default: z <= {32'h0, bus + 32'd1};
        endcase
      end
      for (int n = 0; n < 16; n++) if (Rin[n]) regs[n] <= bus;
    end
  end

  localparam logic [13:0] S_PCOUT = 14'h2000, S_ZLOW = 14'h1000, S_ZHIGH = 14'h0800,
                          S_MDROUT = 14'h0400, S_MARIN = 14'h0200, S_PCIN = 14'h0100,
                          S_MDRIN = 14'h0080, S_IRIN = 14'h0040, S_YIN = 14'h0020,
                          S_ZIN = 14'h0010, S_HIIN = 14'h0008, S_LOIN = 14'h0004,
                          S_INCPC = 14'h0002, S_READ = 14'h0001;

  typedef struct {
    string       tag;
    logic [52:0] exp;
    logic        mr;
    logic        clr;
  } step_t;

  step_t       q[$];
  int          passed, total, exp_cnt;
  logic [52:0] obs;
  int          bus_srcs;

  assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
                HIin, LOin, IncPC, Read, Rout, Rin, operation, Run, ill_op, mem_err};
  assign bus_srcs = int'($countones({PCout, Zlowout, Zhighout, MDRout, Rout}));

  function automatic logic [52:0] v(input logic [13:0] s, input logic [15:0] ro,
                                    input logic [15:0] ri, input logic [3:0] op,
                                    input logic run, input logic ill, input logic merr);
    return {s, ro, ri, op, run, ill, merr};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  function automatic void push(input string tag, input logic [52:0] e, input logic mr,
                               input logic clr);
    step_t s;
    s.tag = tag; s.exp = e; s.mr = mr; s.clr = clr;
    q.push_back(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic run_queue();
    step_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      MemReady = e.mr;
      clear    = e.clr;
      chk(e.tag, 64'(obs), 64'(e.exp));
      chk({e.tag, "_bus"}, 64'(bus_srcs <= 1), 64'd1);
      @(posedge Clock); #1;
    end
    MemReady = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic push_fetch(input int w);
    push("T0", v(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    for (int k = 0; k <= w; k++)
      push("T1", v(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), k == w, 1'b0);
    push("T2", v(S_MDROUT | S_IRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt"}, 64'(instr_cnt), 64'(exp_cnt[15:0]));
    chk({tag, "_cnt2"}, 64'(d2_instr_cnt), 64'(exp_cnt[1:0]));
  endtask

  localparam logic [52:0] RST_V = 53'h0 | (53'h1 << 2);

  initial begin
    passed = 0; total = 0; exp_cnt = 0;
    clear = 1'b1; preload = 1'b1; MemReady = 1'b0; mem_word = 32'h0;
    @(posedge Clock); #1;
    clear = 1'b0; preload = 1'b0;
    push("RST", RST_V, 1'b0, 1'b0);
    run_queue();
    chk_cnt("reset");

    // ADD R1 = R2 + R3
    mem_word = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
    push_fetch(0);
    push("ADD_T3", v(S_YIN, 16'h0004, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("ADD_T4", v(S_ZIN, 16'h0008, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("ADD_T5", v(S_ZLOW, 16'h0, 16'h0002, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    run_queue();
    exp_cnt = 1; chk_cnt("add");
    chk("add_r1", 64'(regs[1]), 64'h26);

    // MUL R4 * R5 with three MemReady wait cycles
    mem_word = mk_ir(5'b01110, 4'd4, 4'd5, 4'd0);
    push_fetch(3);
    push("MUL_T3", v(S_YIN, 16'h0010, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("MUL_T4", v(S_ZIN, 16'h0020, 16'h0, 4'd9, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("MUL_T5", v(S_ZLOW | S_LOIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("MUL_T6", v(S_ZHIGH | S_HIIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    run_queue();
    exp_cnt = 2; chk_cnt("mul");
    chk("mul_lo", 64'(lo), 64'h30);
    chk("mul_hi", 64'(hi), 64'h0);

    // NEG R6 = -R2
    mem_word = mk_ir(5'b10000, 4'd6, 4'd2, 4'd0);
    push_fetch(1);
    push("NEG_T3", v(S_ZIN, 16'h0004, 16'h0, 4'd11, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("NEG_T4", v(S_ZLOW, 16'h0, 16'h0040, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    run_queue();
    exp_cnt = 3; chk_cnt("neg");
    chk("neg_r6", 64'(regs[6]), 64'hFFFF_FFEE);

    // NOP: fourth instruction wraps the 2-bit counter
    mem_word = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
    push_fetch(0);
    push("NOP_T3", v(14'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    run_queue();
    exp_cnt = 4; chk_cnt("nop_wrap");

    // Illegal opcode 11111
    mem_word = mk_ir(5'b11111, 4'd7, 4'd2, 4'd3);
    push_fetch(0);
    push("ILL_T3", v(14'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    run_queue();
    exp_cnt = 5; chk_cnt("ill");
    chk("ill_r7", 64'(regs[7]), 64'h0);

    // ADD into R0: load strobe suppressed
    mem_word = mk_ir(5'b00011, 4'd0, 4'd2, 4'd3);
    push_fetch(0);
    push("R0_T3", v(S_YIN, 16'h0004, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("R0_T4", v(S_ZIN, 16'h0008, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("R0_T5", v(S_ZLOW, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    run_queue();
    exp_cnt = 6; chk_cnt("r0");
    chk("r0_val", 64'(regs[0]), 64'h0);

    // clear during T4 of ADD R9 = R2 + R3
    mem_word = mk_ir(5'b00011, 4'd9, 4'd2, 4'd3);
    push_fetch(0);
    push("CLR_T3", v(S_YIN, 16'h0004, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("CLR_T4", v(S_ZIN, 16'h0008, 16'h0, 4'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1);
    push("CLR_RST", RST_V, 1'b0, 1'b0);
    run_queue();
    exp_cnt = 0; chk_cnt("midclr");
    chk("midclr_r9", 64'(regs[9]), 64'h0);

    // HALT, held until clear
    mem_word = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
    push_fetch(0);
    push("HALT_T3", v(14'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      push("HALTED", v(14'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    run_queue();
    exp_cnt = 1; chk_cnt("halt");
    push("HALTED_CLR", v(14'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1);
    push("HALT_RST", RST_V, 1'b0, 1'b0);
    run_queue();
    exp_cnt = 0; chk_cnt("halt_clr");

    // MemReady never arrives: 15 T1 cycles then HALTED with mem_err
    push("TO_T0", v(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    for (int k = 0; k < 15; k++)
      push("TO_T1", v(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    push("TO_HALTED", v(14'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
    push("TO_HALTED_CLR", v(14'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1);
    push("TO_RST", RST_V, 1'b0, 1'b0);
    run_queue();
    chk_cnt("timeout");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
